garegga_gfx_rom_arb: RTL and testbench

//  Shares one graphics-ROM SDRAM port between the four GP9001 tile fetchers (OBJ, SCR0, SCR1, SCR2).

---
 rtl/garegga_gfx_rom_arb.sv | 155 +++++++++++++++
 tb/tb_garegga_gfx_rom_arb.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/garegga_gfx_rom_arb.sv
// Graphics-ROM port arbiter: shares one SDRAM slot between the four GP9001 tile fetchers (OBJ, SCR0-2).
// Optional last-address hit cache per requester is enabled by defining GFX_ARB_HITCACHE_EN.

module garegga_gfx_rom_arb #(
    parameter int unsigned AW       = 22,
    parameter int unsigned DW       = 32,
    parameter int unsigned OBJ_PRIO = 1,
    parameter int unsigned WDOG     = 255
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic [3:0]      REQ_CS,
    input  logic [4*AW-1:0] REQ_ADDR,
    output logic [3:0]      REQ_OK,
    output logic [4*DW-1:0] REQ_DOUT,
    output logic            ROM_CS,
    output logic [AW-1:0]   ROM_ADDR,
    input  logic            ROM_OK,
    input  logic [DW-1:0]   ROM_DOUT,
    output logic            BUSY,
    output logic            WDOG_ERR
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state;
    logic [1:0]    rr_ptr;
    logic [1:0]    gnt;
    logic [1:0]    win_idx;
    logic [1:0]    cand;
    logic          win_vld;
    logic          win_hit;
    logic [7:0]    wdog_cnt;
    logic [AW-1:0] req_addr_a [4];
    logic [DW-1:0] dout_q     [4];

    for (genvar g = 0; g < 4; g++) begin : g_lane
        assign req_addr_a[g]          = REQ_ADDR[g*AW +: AW];
        assign REQ_DOUT[g*DW +: DW]   = dout_q[g];
    end

    // OBJ may pre-empt the rotation; otherwise scan upward from the pointer with wrap.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        if (OBJ_PRIO != 0 && REQ_CS[0]) begin
            win_vld = 1'b1;
            win_idx = 2'd0;
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                cand = rr_ptr + 2'(i);
                if (!win_vld && REQ_CS[cand]) begin
                    win_vld = 1'b1;
                    win_idx = cand;
                end
            end
        end
    end

`ifdef GFX_ARB_HITCACHE_EN
    logic [3:0]    hc_vld;
    logic [AW-1:0] hc_addr [4];

    assign win_hit = hc_vld[win_idx] && (hc_addr[win_idx] == req_addr_a[win_idx]);
`else
    assign win_hit = 1'b0;
`endif

    assign BUSY = (state != IDLE);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= IDLE;
            REQ_OK   <= '0;
            ROM_CS   <= 1'b0;
            ROM_ADDR <= '0;
            WDOG_ERR <= 1'b0;
            rr_ptr   <= '0;
            gnt      <= '0;
            wdog_cnt <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                dout_q[i] <= '0;
            end
`ifdef GFX_ARB_HITCACHE_EN
            hc_vld <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                hc_addr[i] <= '0;
            end
`endif
        end else begin
            case (state)
                IDLE: begin
                    REQ_OK <= '0;
                    if (win_vld) begin
                        gnt      <= win_idx;
                        rr_ptr   <= win_idx + 2'd1;
                        wdog_cnt <= '0;
                        if (win_hit) begin
                            REQ_OK[win_idx] <= 1'b1;
                            state           <= DONE;
                        end else begin
                            ROM_CS   <= 1'b1;
                            ROM_ADDR <= req_addr_a[win_idx];
                            state    <= ISSUE;
                        end
                    end
                end

                ISSUE: begin
                    if (ROM_OK) begin
                        ROM_CS <= 1'b0;
                        // A requester that withdrew keeps its previous data and gets no pulse.
                        if (REQ_CS[gnt]) begin
                            dout_q[gnt] <= ROM_DOUT;
                            REQ_OK[gnt] <= 1'b1;
`ifdef GFX_ARB_HITCACHE_EN
                            hc_vld[gnt]  <= 1'b1;
                            hc_addr[gnt] <= ROM_ADDR;
`endif
                        end
                        state <= DONE;
                    end else if (wdog_cnt == 8'(WDOG)) begin
                        ROM_CS      <= 1'b0;
                        dout_q[gnt] <= '0;
                        if (REQ_CS[gnt]) begin
                            REQ_OK[gnt] <= 1'b1;
                        end
`ifdef GFX_ARB_HITCACHE_EN
                        hc_vld[gnt] <= 1'b0;
`endif
                        WDOG_ERR <= 1'b1;
                        state    <= DONE;
                    end else begin
                        wdog_cnt <= wdog_cnt + 8'd1;
                    end
                end

                DONE: begin
                    REQ_OK <= '0;
                    state  <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_garegga_gfx_rom_arb.sv
// Bench for garegga_gfx_rom_arb: directed scenarios plus random traffic against a transaction-level model.
// Two instances (round-robin only and OBJ priority) share stimulus; sel picks the one being checked.

module tb_garegga_gfx_rom_arb;

    localparam int AW = 22;
    localparam int DW = 32;
`ifdef GFX_ARB_HITCACHE_EN
    localparam bit HC = 1'b1;
`else
    localparam bit HC = 1'b0;
`endif

    logic            clk;
    logic            rst_n;
    logic [3:0]      cs;
    logic [AW-1:0]   ad [4];
    logic [4*AW-1:0] req_addr;
    logic            rom_ok;
    logic [DW-1:0]   rom_dout;
    logic            sel;

    logic [3:0]      a_req_ok,   b_req_ok,   o_req_ok;
    logic [4*DW-1:0] a_req_dout, b_req_dout, o_req_dout;
    logic            a_rom_cs,   b_rom_cs,   o_rom_cs;
    logic [AW-1:0]   a_rom_addr, b_rom_addr, o_rom_addr;
    logic            a_busy,     b_busy,     o_busy;
    logic            a_werr,     b_werr,     o_werr;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    int            ptr;
    bit            prio;
    logic [DW-1:0] de [4];
    bit            werr;
    bit            hv [4];
    logic [AW-1:0] ha [4];

    assign req_addr = {ad[3], ad[2], ad[1], ad[0]};

    garegga_gfx_rom_arb #(.AW(AW), .DW(DW), .OBJ_PRIO(0), .WDOG(255)) u_rr (
        .CLK(clk), .RESET_N(rst_n), .REQ_CS(cs), .REQ_ADDR(req_addr),
        .REQ_OK(a_req_ok), .REQ_DOUT(a_req_dout), .ROM_CS(a_rom_cs), .ROM_ADDR(a_rom_addr),
        .ROM_OK(rom_ok), .ROM_DOUT(rom_dout), .BUSY(a_busy), .WDOG_ERR(a_werr)
    );

    garegga_gfx_rom_arb #(.AW(AW), .DW(DW), .OBJ_PRIO(1), .WDOG(255)) u_op (
        .CLK(clk), .RESET_N(rst_n), .REQ_CS(cs), .REQ_ADDR(req_addr),
        .REQ_OK(b_req_ok), .REQ_DOUT(b_req_dout), .ROM_CS(b_rom_cs), .ROM_ADDR(b_rom_addr),
        .ROM_OK(rom_ok), .ROM_DOUT(rom_dout), .BUSY(b_busy), .WDOG_ERR(b_werr)
    );

    assign o_req_ok   = sel ? b_req_ok   : a_req_ok;
    assign o_req_dout = sel ? b_req_dout : a_req_dout;
    assign o_rom_cs   = sel ? b_rom_cs   : a_rom_cs;
    assign o_rom_addr = sel ? b_rom_addr : a_rom_addr;
    assign o_busy     = sel ? b_busy     : a_busy;
    assign o_werr     = sel ? b_werr     : a_werr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] exp_dout();
        return {de[3], de[2], de[1], de[0]};
    endfunction

    function automatic int pick(input logic [3:0] c, input int p, input bit pr);
        if (pr && c[0]) return 0;
        for (int k = 0; k < 4; k++) begin
            if (c[(p + k) % 4]) return (p + k) % 4;
        end
        return 0;
    endfunction

    task automatic set_addr(input int i);
        ad[i] = {20'($urandom), 2'(i)};
        if (hv[i] && ha[i] == ad[i]) ad[i][2] = ~ad[i][2];
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        cs     = '0;
        rom_ok = 1'b0;
        ptr    = 0;
        werr   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            de[i] = '0;
            hv[i] = 1'b0;
            ha[i] = '0;
        end
        repeat (2) tick();
        chk("rst_req_ok",   128'(o_req_ok),   128'(4'b0));
        chk("rst_req_dout", o_req_dout,       128'(0));
        chk("rst_rom_cs",   128'(o_rom_cs),   128'(1'b0));
        chk("rst_rom_addr", 128'(o_rom_addr), 128'(0));
        chk("rst_busy",     128'(o_busy),     128'(1'b0));
        chk("rst_wdog_err", 128'(o_werr),     128'(1'b0));
        rst_n = 1'b1;
        tick();
    endtask

    // One arbitration round starting from IDLE with the current cs/ad.
    task automatic xact(input int lat, input logic [DW-1:0] d, input bit drop);
        int         w;
        bit         hit;
        logic [3:0] eok;
        if (cs == 4'b0) cs = 4'b0001;
        w   = pick(cs, ptr, prio);
        hit = HC && hv[w] && (ha[w] == ad[w]);
        ptr = (w + 1) % 4;
        eok = 4'(1 << w);
        tick();
        chk("busy_after_grant", 128'(o_busy), 128'(1'b1));
        if (hit) begin
            chk("hit_no_rom_cs", 128'(o_rom_cs), 128'(1'b0));
            chk("hit_req_ok",    128'(o_req_ok), 128'(eok));
            chk("hit_req_dout",  o_req_dout,     exp_dout());
        end else begin
            chk("grant_rom_cs",   128'(o_rom_cs),   128'(1'b1));
            chk("grant_rom_addr", 128'(o_rom_addr), 128'(ad[w]));
            if (drop) cs[w] = 1'b0;
            repeat (lat) tick();
            chk("rom_cs_held",     128'(o_rom_cs),   128'(1'b1));
            chk("rom_addr_stable", 128'(o_rom_addr), 128'(ad[w]));
            rom_ok   = 1'b1;
            rom_dout = d;
            tick();
            rom_ok   = 1'b0;
            rom_dout = $urandom;
            chk("rom_cs_drop", 128'(o_rom_cs), 128'(1'b0));
            if (!drop) begin
                de[w] = d;
                hv[w] = 1'b1;
                ha[w] = ad[w];
            end
            chk("req_ok",   128'(o_req_ok), 128'(drop ? 4'b0 : eok));
            chk("req_dout", o_req_dout,     exp_dout());
        end
        tick();
        chk("req_ok_pulse_end", 128'(o_req_ok), 128'(4'b0));
        chk("back_to_idle",     128'(o_busy),   128'(1'b0));
        chk("wdog_err_state",   128'(o_werr),   128'(werr));
    endtask

    task automatic wdog_test(input int r);
        cs    = '0;
        set_addr(r);
        cs[r] = 1'b1;
        ptr   = (r + 1) % 4;
        tick();
        chk("wdog_grant", 128'(o_rom_cs), 128'(1'b1));
        repeat (255) tick();
        chk("wdog_cs_at_255",   128'(o_rom_cs), 128'(1'b1));
        chk("wdog_err_not_yet", 128'(o_werr),   128'(werr));
        tick();
        de[r] = '0;
        hv[r] = 1'b0;
        werr  = 1'b1;
        chk("wdog_cs_low",   128'(o_rom_cs), 128'(1'b0));
        chk("wdog_req_ok",   128'(o_req_ok), 128'(4'(1 << r)));
        chk("wdog_req_dout", o_req_dout,     exp_dout());
        chk("wdog_err_set",  128'(o_werr),   128'(1'b1));
        tick();
        chk("wdog_ok_end", 128'(o_req_ok), 128'(4'b0));
        cs[r] = 1'b0;
    endtask

    task automatic rand_phase(input int n);
        for (int t = 0; t < n; t++) begin
            cs = 4'($urandom_range(1, 15));
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 2) == 0) set_addr(i);
            end
            xact(int'($urandom_range(0, 6)), $urandom, ($urandom_range(0, 7) == 0));
        end
        cs = '0;
    endtask

    initial begin
        sel      = 1'b0;
        prio     = 1'b0;
        rst_n    = 1'b0;
        cs       = '0;
        rom_ok   = 1'b0;
        rom_dout = '0;
        for (int i = 0; i < 4; i++) begin
            ad[i] = '0;
            hv[i] = 1'b0;
            ha[i] = '0;
        end

        // Round-robin instance: reset values, then a single SCR0 read.
        do_reset();
        for (int i = 0; i < 4; i++) set_addr(i);
        ad[1] = 22'h0ABCDE;
        cs    = 4'b0010;
        xact(3, 32'h1234_5678, 1'b0);
        cs = '0;

        // ROM_OK outside ISSUE must be ignored.
        rom_ok   = 1'b1;
        rom_dout = 32'hFFFF_FFFF;
        repeat (2) tick();
        chk("stray_ok_rom_cs",   128'(o_rom_cs), 128'(1'b0));
        chk("stray_ok_req_ok",   128'(o_req_ok), 128'(4'b0));
        chk("stray_ok_busy",     128'(o_busy),   128'(1'b0));
        chk("stray_ok_req_dout", o_req_dout,     exp_dout());
        rom_ok = 1'b0;
        tick();

        // All four held: rotation 0,1,2,3,0.
        do_reset();
        for (int i = 0; i < 4; i++) set_addr(i);
        cs = 4'b1111;
        repeat (5) xact(int'($urandom_range(0, 4)), $urandom, 1'b0);

        // SCR1 withdraws mid-access, SCR2 is granted next.
        cs = 4'b1100;
        set_addr(2);
        set_addr(3);
        xact(4, 32'hDEAD_0002, 1'b1);
        xact(2, 32'hBEEF_0003, 1'b0);
        cs = '0;
        tick();

        // SCR2 reads the same address twice.
        ad[3] = 22'h000100;
        cs    = 4'b1000;
        xact(2, 32'hCAFE_0100, 1'b0);
        cs = '0;
        tick();
        cs = 4'b1000;
        xact(3, 32'h5555_AAAA, 1'b0);
        cs = '0;

        wdog_test(1);

        // Async reset in the middle of an access.
        cs = 4'b0010;
        set_addr(1);
        tick();
        chk("midrst_grant", 128'(o_rom_cs), 128'(1'b1));
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_rom_cs",   128'(o_rom_cs),   128'(1'b0));
        chk("midrst_busy",     128'(o_busy),     128'(1'b0));
        chk("midrst_req_dout", o_req_dout,       128'(0));
        chk("midrst_wdog_err", 128'(o_werr),     128'(1'b0));
        ptr  = 0;
        werr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            de[i] = '0;
            hv[i] = 1'b0;
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) set_addr(i);
        cs = 4'b1111;
        xact(1, $urandom, 1'b0);
        cs = '0;

        rand_phase(40);

        // OBJ-priority instance.
        sel  = 1'b1;
        prio = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) set_addr(i);
        cs = 4'b1111;
        repeat (3) xact(int'($urandom_range(0, 4)), $urandom, 1'b0);
        cs = 4'b1110;
        xact(2, $urandom, 1'b0);
        cs = '0;
        rand_phase(40);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
